// File: rtl/xor_parity_accum_pkg.sv
// Shared types and helpers for the XOR parity accumulator.
package xor_parity_accum_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bits needed to hold a count of 0..max_words.
  function automatic int unsigned count_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/xor_word.sv
// Word-wide XOR gate: bitwise y = a ^ b.
module xor_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_parity_accum.sv
// Frame-wise column XOR accumulator with reduction parity, word count and overflow flag.
module xor_parity_accum
  import xor_parity_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  parameter bit          ODD       = 1'b0,
  localparam int unsigned CW       = count_width(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_xor;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             beat;

  xor_word #(
    .WIDTH(WIDTH)
  ) u_xor_word (
    .a(acc_q),
    .b(in_data),
    .y(acc_xor)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          acc_d   = in_data;
          count_d = CW'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d = acc_xor;
          // Count saturates at the limit; overflow stays set until the frame is consumed.
          if (count_q == CW'(MAX_WORDS)) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (in_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Results are gated to zero outside DONE so partial sums never leak out.
  always_comb begin
    in_ready     = (state_q != StDone);
    out_valid    = (state_q == StDone);
    out_parity   = out_valid ? acc_q : '0;
    out_count    = out_valid ? count_q : '0;
    out_overflow = out_valid ? ovf_q : 1'b0;
    out_bit      = (^out_parity) ^ ODD;
  end

endmodule

// File: tb/tb_xor_parity_accum.sv
// Directed bench: main instance (MAX_WORDS=4, even) plus a shadow instance (MAX_WORDS=1, odd).
module tb_xor_parity_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, out_valid, out_bit, out_overflow;
  logic [7:0] out_parity;
  logic [2:0] out_count;

  logic       in_ready1, out_valid1, out_bit1, out_overflow1;
  logic [7:0] out_parity1;
  logic [0:0] out_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_parity_accum #(
    .WIDTH(8),
    .MAX_WORDS(4),
    .ODD(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_parity(out_parity),
    .out_bit(out_bit),
    .out_count(out_count),
    .out_overflow(out_overflow)
  );

  xor_parity_accum #(
    .WIDTH(8),
    .MAX_WORDS(1),
    .ODD(1'b1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready1),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .out_parity(out_parity1),
    .out_bit(out_bit1),
    .out_count(out_count1),
    .out_overflow(out_overflow1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] data, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_valid", 32'(out_valid), 32'd0);
    check("consume_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_parity", 32'(out_parity), 32'h00);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_ovf", 32'(out_overflow), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_bit", 32'(out_bit), 32'd0);
    check("rst_bit_odd", 32'(out_bit1), 32'd1);

    // Single-word frame
    send(8'hA5, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_parity", 32'(out_parity), 32'hA5);
    check("single_bit", 32'(out_bit), 32'd0);
    check("single_bit_odd", 32'(out_bit1), 32'd1);
    check("single_count", 32'(out_count), 32'd1);
    check("single_ovf", 32'(out_overflow), 32'd0);
    consume();

    // Three words with a gap
    send(8'h0F, 1'b0);
    tick();
    send(8'hF0, 1'b0);
    send(8'h3C, 1'b1);
    check("frame3_parity", 32'(out_parity), 32'hC3);
    check("frame3_bit", 32'(out_bit), 32'd0);
    check("frame3_bit_odd", 32'(out_bit1), 32'd1);
    check("frame3_count", 32'(out_count), 32'd3);
    check("frame3_ovf", 32'(out_overflow), 32'd0);
    check("frame3_parity_m1", 32'(out_parity1), 32'hC3);
    check("frame3_count_m1", 32'(out_count1), 32'd1);
    check("frame3_ovf_m1", 32'(out_overflow1), 32'd1);

    // Backpressure in DONE with input pushing
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_parity", 32'(out_parity), 32'hC3);
      check("bp_count", 32'(out_count), 32'd3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume();

    // Overflow: six words into a MAX_WORDS=4 frame
    for (int i = 0; i < 6; i++) send(8'h01, i == 5);
    check("ovf_parity", 32'(out_parity), 32'h00);
    check("ovf_bit", 32'(out_bit), 32'd0);
    check("ovf_count", 32'(out_count), 32'd4);
    check("ovf_flag", 32'(out_overflow), 32'd1);
    check("ovf_count_m1", 32'(out_count1), 32'd1);
    consume();
    send(8'h01, 1'b1);
    check("post_ovf_flag", 32'(out_overflow), 32'd0);
    check("post_ovf_count", 32'(out_count), 32'd1);
    check("post_ovf_bit", 32'(out_bit), 32'd1);
    check("post_ovf_bit_odd", 32'(out_bit1), 32'd0);
    consume();

    // Reset mid-frame, with in_valid held high across the reset edge
    send(8'hFF, 1'b0);
    send(8'h11, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_count", 32'(out_count), 32'd0);
    send(8'h55, 1'b1);
    check("midrst_parity", 32'(out_parity), 32'h55);
    check("midrst_count1", 32'(out_count), 32'd1);
    check("midrst_bit", 32'(out_bit), 32'd0);

    // Reset while a result is pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_parity", 32'(out_parity), 32'h00);
    check("donerst_bit", 32'(out_bit), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
